// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control FSM with memory stall/timeout and illegal-opcode exceptions
// Optional JAL support is enabled by defining MC_CTRL_JAL_EN.
module mc_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem2reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       branch_ne,
    output logic       link,
    output logic       exception,
    output logic [1:0] exc_cause,
    output logic       instr_done,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        JR     = 4'd11,
        EXCPT  = 4'd12
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       exc_cause_q, exc_cause_d;
    logic             waiting;
    logic             timeout;
    logic             r_type;

    assign r_type    = (opcode == 6'd0);
    assign waiting   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout   = (TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt_q == TO_LAST);
    assign state_o   = state_q;
    assign exc_cause = exc_cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST;
            wait_cnt_q  <= '0;
            exc_cause_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        exc_cause_d   = exc_cause_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem2reg       = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        branch_ne     = 1'b0;
        link          = 1'b0;
        exception     = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            RST: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)    state_d = DECODE;
                else if (timeout) state_d = EXCPT;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'd0:                                   state_d = (funct == 6'd8) ? JR : EXEC;
                    6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd15: state_d = EXEC;
                    6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43: state_d = MEMADR;
                    6'd4, 6'd5:                             state_d = BRANCH;
                    6'd2:                                   state_d = JUMP;
`ifdef MC_CTRL_JAL_EN
                    6'd3:                                   state_d = JUMP;
`endif
                    default:                                state_d = EXCPT;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Stores (40/41/43) all have opcode bit 3 set; loads (35/36/37) do not.
                state_d   = opcode[3] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)    state_d = MEMWB;
                else if (timeout) state_d = EXCPT;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem2reg    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)    state_d = FETCH;
                else if (timeout) state_d = EXCPT;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = r_type ? 2'b00 : 2'b10;
                alu_op    = r_type ? 2'b10 : 2'b11;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = r_type;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (opcode == 6'd5);
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
`ifdef MC_CTRL_JAL_EN
                link       = (opcode == 6'd3);
                reg_write  = (opcode == 6'd3);
`endif
                state_d    = FETCH;
            end
            JR: begin
                pc_write   = 1'b1;
                pc_src     = 2'b11;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXCPT: begin
                exception = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = RST;
        endcase

        if (state_d == EXCPT && state_q != EXCPT)
            exc_cause_d = (state_q == DECODE) ? 2'b01 : 2'b10;

        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (waiting && !mem_ready)
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        else
            wait_cnt_d = wait_cnt_q;
    end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic       mem2reg, reg_write, reg_dst, alu_src_a, branch_ne, link, exception, instr_done;
    logic [1:0] pc_src, alu_src_b, alu_op, exc_cause;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JR = 4'd11,
                           S_EXCPT = 4'd12;

    localparam logic [19:0] PCW = 20'h1 << 19, PWC = 20'h1 << 18, SRC01 = 20'h1 << 16,
                            SRC10 = 20'h2 << 16, SRC11 = 20'h3 << 16, IORD = 20'h1 << 15,
                            IRW = 20'h1 << 14, MRD = 20'h1 << 13, MWR = 20'h1 << 12,
                            M2R = 20'h1 << 11, RW = 20'h1 << 10, RDST = 20'h1 << 9,
                            SRCA = 20'h1 << 8, B01 = 20'h1 << 6, B10 = 20'h2 << 6,
                            B11 = 20'h3 << 6, OP01 = 20'h1 << 4, OP10 = 20'h2 << 4,
                            OP11 = 20'h3 << 4, BNE = 20'h1 << 3, LNK = 20'h1 << 2,
                            EXC = 20'h1 << 1, DONE = 20'h1;
    localparam logic [19:0] FETCH_OK = PCW | IRW | MRD | B01;

    logic [19:0] ctl;
    assign ctl = {pc_write, pc_write_cond, pc_src, i_or_d, ir_write, mem_read, mem_write,
                  mem2reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                  branch_ne, link, exception, instr_done};

    mc_control #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .i_or_d(i_or_d), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem2reg(mem2reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .branch_ne(branch_ne), .link(link), .exception(exception),
        .exc_cause(exc_cause), .instr_done(instr_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive mem_ready for the current cycle, check state and controls, then advance.
    task automatic cyc(input string tag, input logic mr, input logic [3:0] st, input logic [19:0] c);
        mem_ready = mr;
        #1;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".ctl"}, 32'(ctl), 32'(c));
        step();
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        step();
        check("reset.state", 32'(state_o), 32'(S_RST));
        check("reset.ctl", 32'(ctl), 32'h0);
        check("reset.cause", 32'(exc_cause), 32'h0);
        rst_n = 1'b1;
        cyc("rst_release", 1'b1, S_RST, 20'h0);

        set_instr(6'd0, 6'd32);
        cyc("add.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("add.d", 1'b1, S_DECODE, B11);
        cyc("add.e", 1'b1, S_EXEC, SRCA | OP10);
        cyc("add.wb", 1'b1, S_ALUWB, RW | RDST | DONE);

        set_instr(6'd35, 6'd0);
        cyc("lw.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("lw.d", 1'b1, S_DECODE, B11);
        cyc("lw.ma", 1'b1, S_MEMADR, SRCA | B10);
        for (int i = 0; i < 3; i++) cyc("lw.rd_wait", 1'b0, S_MEMRD, IORD | MRD);
        cyc("lw.rd", 1'b1, S_MEMRD, IORD | MRD);
        cyc("lw.wb", 1'b1, S_MEMWB, RW | M2R | DONE);

        set_instr(6'd43, 6'd0);
        cyc("sw.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("sw.d", 1'b1, S_DECODE, B11);
        cyc("sw.ma", 1'b1, S_MEMADR, SRCA | B10);
        cyc("sw.wr", 1'b1, S_MEMWR, IORD | MWR | DONE);

        set_instr(6'd5, 6'd0);
        cyc("bne.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("bne.d", 1'b1, S_DECODE, B11);
        cyc("bne.br", 1'b1, S_BRANCH, SRCA | OP01 | PWC | SRC01 | BNE | DONE);

        set_instr(6'd8, 6'd0);
        cyc("addi.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("addi.d", 1'b1, S_DECODE, B11);
        cyc("addi.e", 1'b1, S_EXEC, SRCA | B10 | OP11);
        cyc("addi.wb", 1'b1, S_ALUWB, RW | DONE);

        set_instr(6'd2, 6'd0);
        cyc("j.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("j.d", 1'b1, S_DECODE, B11);
        cyc("j.j", 1'b1, S_JUMP, PCW | SRC10 | DONE);

        set_instr(6'd0, 6'd8);
        cyc("jr.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("jr.d", 1'b1, S_DECODE, B11);
        cyc("jr.jr", 1'b1, S_JR, PCW | SRC11 | DONE);

        set_instr(6'd63, 6'd0);
        cyc("ill.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("ill.d", 1'b1, S_DECODE, B11);
        check("ill.cause", 32'(exc_cause), 32'h1);
        cyc("ill.x", 1'b1, S_EXCPT, EXC);

        // 15 stalled fetches, then ready on the last permitted cycle completes normally.
        set_instr(6'd2, 6'd0);
        for (int i = 0; i < 15; i++) cyc("edge.wait", 1'b0, S_FETCH, MRD | B01);
        cyc("edge.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("edge.d", 1'b1, S_DECODE, B11);
        cyc("edge.j", 1'b1, S_JUMP, PCW | SRC10 | DONE);

        for (int i = 0; i < 16; i++) cyc("to.wait", 1'b0, S_FETCH, MRD | B01);
        check("to.cause", 32'(exc_cause), 32'h2);
        cyc("to.x", 1'b1, S_EXCPT, EXC);
        check("to.cause_hold", 32'(exc_cause), 32'h2);

        set_instr(6'd3, 6'd0);
        cyc("jal.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("jal.d", 1'b1, S_DECODE, B11);
`ifdef MC_CTRL_JAL_EN
        cyc("jal.j", 1'b1, S_JUMP, PCW | SRC10 | RW | LNK | DONE);
        check("jal.cause", 32'(exc_cause), 32'h2);
`else
        check("jal.cause", 32'(exc_cause), 32'h1);
        cyc("jal.x", 1'b1, S_EXCPT, EXC);
`endif

        set_instr(6'd35, 6'd0);
        cyc("rlw.f", 1'b1, S_FETCH, FETCH_OK);
        cyc("rlw.d", 1'b1, S_DECODE, B11);
        cyc("rlw.ma", 1'b1, S_MEMADR, SRCA | B10);
        mem_ready = 1'b0;
        #1;
        check("rlw.rd", 32'(ctl), 32'(IORD | MRD));
        rst_n = 1'b0;
        #1;
        check("rst_async.state", 32'(state_o), 32'(S_RST));
        check("rst_async.ctl", 32'(ctl), 32'h0);
        check("rst_async.cause", 32'(exc_cause), 32'h0);
        step();
        rst_n = 1'b1;
        cyc("rst2.rst", 1'b1, S_RST, 20'h0);
        cyc("rst2.f", 1'b1, S_FETCH, FETCH_OK);
        check("rst2.d", 32'(state_o), 32'(S_DECODE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
